// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor code width, named floors, sweep direction
// encodings and the dispatcher state enum.
// Imported by the dispatcher, its interface users and the testbench.
package elevator_pkg;

  localparam int FLOOR_W = 4;

  localparam logic [FLOOR_W-1:0] GROUND = 4'd0;
  localparam logic [FLOOR_W-1:0] FIRST  = 4'd1;
  localparam logic [FLOOR_W-1:0] SECOND = 4'd2;
  localparam logic [FLOOR_W-1:0] THIRD  = 4'd3;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SERVE  = 2'd2,
    DWELL  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/floor_request_dispatcher_if.sv
// Bundle between button panel / elevator controller and the request dispatcher.
// Ports: CALL_BUTTONS, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT feed the
// dispatcher; REQUESTED_FLOOR, REQ_VALID, PENDING, BUSY, TIMEOUT_FAULT come back.
// master = dispatcher side, slave = panel/controller side.
interface floor_request_dispatcher_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 4
);
  logic [NUM_FLOORS-1:0] CALL_BUTTONS;
  logic [FLOOR_W-1:0]    CURRENT_FLOOR;
  logic                  COMPLETE;
  logic                  DOOR_ALERT;
  logic                  WEIGHT_ALERT;
  logic [FLOOR_W-1:0]    REQUESTED_FLOOR;
  logic                  REQ_VALID;
  logic [NUM_FLOORS-1:0] PENDING;
  logic                  BUSY;
  logic                  TIMEOUT_FAULT;

  modport master (
    input  CALL_BUTTONS, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
    output REQUESTED_FLOOR, REQ_VALID, PENDING, BUSY, TIMEOUT_FAULT
  );

  modport slave (
    output CALL_BUTTONS, CURRENT_FLOOR, COMPLETE, DOOR_ALERT, WEIGHT_ALERT,
    input  REQUESTED_FLOOR, REQ_VALID, PENDING, BUSY, TIMEOUT_FAULT
  );
endinterface

// File: rtl/scan_floor_selector.sv
// SCAN target picker: nearest pending floor in the sweep direction, else reverse.
// Ports: pending (call set), current_floor, sweep_up in; next_floor, found,
// new_sweep_up out. Purely combinational; current_floor >= NUM_FLOORS yields found=0.
module scan_floor_selector #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 4
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  sweep_up,
  output logic [FLOOR_W-1:0]    next_floor,
  output logic                  found,
  output logic                  new_sweep_up
);

  logic                 above_found;
  logic                 below_found;
  logic [FLOOR_W-1:0]   above_floor;
  logic [FLOOR_W-1:0]   below_floor;
  logic                 cur_valid;

  assign cur_valid = 32'(current_floor) < 32'(NUM_FLOORS);

  always_comb begin
    above_found = 1'b0;
    above_floor = '0;
    below_found = 1'b0;
    below_floor = '0;
    // Descending scan: the last hit is the lowest floor above the car.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
        above_found = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    // Ascending scan: the last hit is the highest floor below the car.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
        below_found = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    next_floor   = '0;
    found        = 1'b0;
    new_sweep_up = sweep_up;
    if (cur_valid) begin
      if (sweep_up) begin
        if (above_found) begin
          next_floor = above_floor;
          found      = 1'b1;
        end else if (below_found) begin
          next_floor   = below_floor;
          found        = 1'b1;
          new_sweep_up = 1'b0;
        end
      end else begin
        if (below_found) begin
          next_floor = below_floor;
          found      = 1'b1;
        end else if (above_found) begin
          next_floor   = above_floor;
          found        = 1'b1;
          new_sweep_up = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/floor_request_dispatcher.sv
// Latches call buttons into a pending set and issues one SCAN-ordered target at a
// time, holding it until arrival, then dwelling DWELL_CYCLES (frozen by alerts).
// Ports: clk, rst (async active-low), bus (floor_request_dispatcher_if.master).
// Optional macro DISPATCH_TIMEOUT_EN adds an arrival watchdog driving TIMEOUT_FAULT.
module floor_request_dispatcher #(
  parameter int NUM_FLOORS     = 4,
  parameter int FLOOR_W        = elevator_pkg::FLOOR_W,
  parameter int DWELL_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  floor_request_dispatcher_if.master  bus
);
  import elevator_pkg::*;

  localparam int DW_W = $clog2(DWELL_CYCLES + 1);

  disp_state_t           state, state_nxt;
  logic [NUM_FLOORS-1:0] pending, pending_clr, btn_hist, btn_rise;
  logic [FLOOR_W-1:0]    req_floor, req_floor_nxt;
  logic                  req_vld, req_vld_nxt;
  logic                  sweep_up, sweep_up_nxt;
  logic                  serve_first, serve_first_nxt;
  logic [DW_W-1:0]       dwell_cnt, dwell_cnt_nxt;

  logic                  alert;
  logic                  cur_valid;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] req_mask;
  logic                  arrival;
  logic                  tmo_hit;

  logic [FLOOR_W-1:0]    sel_floor;
  logic                  sel_found;
  logic                  sel_sweep;

  assign alert     = bus.DOOR_ALERT | bus.WEIGHT_ALERT;
  assign cur_valid = 32'(bus.CURRENT_FLOOR) < 32'(NUM_FLOORS);
  assign cur_mask  = cur_valid ? (NUM_FLOORS'(1) << bus.CURRENT_FLOOR) : '0;
  assign req_mask  = NUM_FLOORS'(1) << req_floor;
  assign btn_rise  = bus.CALL_BUTTONS & ~btn_hist;

  // The entry cycle of SERVE ignores COMPLETE so a stale arrival flag from the
  // previous trip cannot retire the new target.
  assign arrival = (state == SERVE) && !serve_first && bus.COMPLETE &&
                   (bus.CURRENT_FLOOR == req_floor);

  scan_floor_selector #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_sel (
    .pending       (pending),
    .current_floor (bus.CURRENT_FLOOR),
    .sweep_up      (sweep_up),
    .next_floor    (sel_floor),
    .found         (sel_found),
    .new_sweep_up  (sel_sweep)
  );

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_fault;

  // tmo_cnt holds (SERVE cycle number - 1), so the fault lands on the edge that
  // closes SERVE cycle TIMEOUT_CYCLES.
  assign tmo_hit = (state == SERVE) && !arrival && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      tmo_fault <= 1'b0;
    end else begin
      tmo_cnt <= (state == SERVE) ? tmo_cnt + TW'(1) : '0;
      if (tmo_hit) tmo_fault <= 1'b1;
    end
  end

  assign bus.TIMEOUT_FAULT = tmo_fault;
`else
  assign tmo_hit           = 1'b0;
  assign bus.TIMEOUT_FAULT = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pending     <= '0;
      btn_hist    <= '0;
      req_floor   <= '0;
      req_vld     <= 1'b0;
      sweep_up    <= UP;
      serve_first <= 1'b0;
      dwell_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      // Clearing beats a same-cycle press for the same floor.
      pending     <= (pending | btn_rise) & ~pending_clr;
      btn_hist    <= bus.CALL_BUTTONS;
      req_floor   <= req_floor_nxt;
      req_vld     <= req_vld_nxt;
      sweep_up    <= sweep_up_nxt;
      serve_first <= serve_first_nxt;
      dwell_cnt   <= dwell_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pending_clr     = '0;
    req_floor_nxt   = req_floor;
    req_vld_nxt     = req_vld;
    sweep_up_nxt    = sweep_up;
    serve_first_nxt = 1'b0;
    dwell_cnt_nxt   = dwell_cnt;
    case (state)
      IDLE: begin
        if (|(pending & cur_mask)) begin
          // Car is already here: retire the call without a trip.
          pending_clr = cur_mask;
        end else if ((|pending) && !alert && cur_valid) begin
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          req_floor_nxt   = sel_floor;
          req_vld_nxt     = 1'b1;
          sweep_up_nxt    = sel_sweep;
          serve_first_nxt = 1'b1;
          state_nxt       = SERVE;
        end else begin
          // Only the current floor was pending; IDLE retires it.
          state_nxt = IDLE;
        end
      end
      SERVE: begin
        if (arrival) begin
          pending_clr   = req_mask;
          req_vld_nxt   = 1'b0;
          dwell_cnt_nxt = DW_W'(DWELL_CYCLES);
          state_nxt     = DWELL;
        end else if (tmo_hit) begin
          // Target stays pending so it is retried after the dwell.
          req_vld_nxt   = 1'b0;
          dwell_cnt_nxt = DW_W'(DWELL_CYCLES);
          state_nxt     = DWELL;
        end
      end
      DWELL: begin
        if (!alert) begin
          if (dwell_cnt <= DW_W'(1)) begin
            dwell_cnt_nxt = '0;
            state_nxt     = IDLE;
          end else begin
            dwell_cnt_nxt = dwell_cnt - DW_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.REQUESTED_FLOOR = req_floor;
  assign bus.REQ_VALID       = req_vld;
  assign bus.PENDING         = pending;
  assign bus.BUSY            = (state != IDLE);

endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Self-checking bench for floor_request_dispatcher: dispatch-latency vector table,
// directed multi-cycle sequences, and randomized call sets against a SCAN model.
// Honours DISPATCH_TIMEOUT_EN when the same macro is defined for the build.
module tb_floor_request_dispatcher;
  import elevator_pkg::*;

  localparam int NF = 4;
  localparam int FW = 4;
  localparam int DW = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  floor_request_dispatcher_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  floor_request_dispatcher #(
    .NUM_FLOORS     (NF),
    .FLOOR_W        (FW),
    .DWELL_CYCLES   (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [FW-1:0] cur;
    logic [NF-1:0] press;
    logic          exp_vld;
    logic [FW-1:0] exp_floor;
    logic [NF-1:0] exp_pend;
  } vec_t;

  vec_t vecs[8];

  bit model_up;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst                = 1'b0;
    bus.CALL_BUTTONS   = '0;
    bus.CURRENT_FLOOR  = '0;
    bus.COMPLETE       = 1'b0;
    bus.DOOR_ALERT     = 1'b0;
    bus.WEIGHT_ALERT   = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    model_up = 1'b1;
  endtask

  task automatic press(input logic [NF-1:0] mask);
    bus.CALL_BUTTONS = mask;
    tick(1);
    bus.CALL_BUTTONS = '0;
  endtask

  task automatic wait_vld(output int cyc, input int budget);
    cyc = 0;
    while (!bus.REQ_VALID && cyc < budget) begin
      tick(1);
      cyc++;
    end
    if (!bus.REQ_VALID) begin
      checks++;
      failures++;
      $display("FAIL wait_req_valid actual=timeout required=REQ_VALID within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(output int cyc, input int budget);
    cyc = 0;
    while (bus.BUSY && cyc < budget) begin
      tick(1);
      cyc++;
    end
    if (bus.BUSY) begin
      checks++;
      failures++;
      $display("FAIL wait_idle actual=timeout required=BUSY low within %0d cycles", budget);
    end
  endtask

  task automatic arrive(input int floor);
    bus.CURRENT_FLOOR = FW'(floor);
    bus.COMPLETE      = 1'b1;
    tick(1);
    bus.COMPLETE      = 1'b0;
  endtask

  // SCAN rule by distance: nearest pending floor in the sweep direction,
  // otherwise turn around and take the nearest on the other side.
  function automatic int model_next(input bit [NF-1:0] s, input int cur);
    int best_up = -1;
    int best_dn = -1;
    for (int f = 0; f < NF; f++) begin
      if (s[f]) begin
        if (f > cur && (best_up < 0 || (f - cur) < (best_up - cur))) best_up = f;
        if (f < cur && (best_dn < 0 || (cur - f) < (cur - best_dn))) best_dn = f;
      end
    end
    if (model_up) begin
      if (best_up >= 0) return best_up;
      model_up = 1'b0;
      return best_dn;
    end else begin
      if (best_dn >= 0) return best_dn;
      model_up = 1'b1;
      return best_up;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog actual=hung required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int cyc;
    int n;
    int cur;
    int tgt;
    bit [NF-1:0] mset;

    vecs[0] = '{cur: 4'd0, press: 4'b0100, exp_vld: 1'b1, exp_floor: 4'd2, exp_pend: 4'b0100};
    vecs[1] = '{cur: 4'd1, press: 4'b1001, exp_vld: 1'b1, exp_floor: 4'd3, exp_pend: 4'b1001};
    vecs[2] = '{cur: 4'd3, press: 4'b0011, exp_vld: 1'b1, exp_floor: 4'd1, exp_pend: 4'b0011};
    vecs[3] = '{cur: 4'd2, press: 4'b1010, exp_vld: 1'b1, exp_floor: 4'd3, exp_pend: 4'b1010};
    vecs[4] = '{cur: 4'd1, press: 4'b0010, exp_vld: 1'b0, exp_floor: 4'd0, exp_pend: 4'b0000};
    vecs[5] = '{cur: 4'd0, press: 4'b1110, exp_vld: 1'b1, exp_floor: 4'd1, exp_pend: 4'b1110};
    vecs[6] = '{cur: 4'd3, press: 4'b0100, exp_vld: 1'b1, exp_floor: 4'd2, exp_pend: 4'b0100};
    vecs[7] = '{cur: 4'd9, press: 4'b0001, exp_vld: 1'b0, exp_floor: 4'd0, exp_pend: 4'b0001};

    // Reset values while rst is held low.
    rst               = 1'b0;
    bus.CALL_BUTTONS  = '0;
    bus.CURRENT_FLOOR = '0;
    bus.COMPLETE      = 1'b0;
    bus.DOOR_ALERT    = 1'b0;
    bus.WEIGHT_ALERT  = 1'b0;
    #1;
    chk("reset_req_floor", 32'(bus.REQUESTED_FLOOR), 0);
    chk("reset_req_valid", 32'(bus.REQ_VALID), 0);
    chk("reset_pending",   32'(bus.PENDING), 0);
    chk("reset_busy",      32'(bus.BUSY), 0);
    chk("reset_fault",     32'(bus.TIMEOUT_FAULT), 0);

    // Table: single press from idle after reset (sweep up), fixed latency.
    foreach (vecs[k]) begin
      do_reset();
      bus.CURRENT_FLOOR = vecs[k].cur;
      tick(1);
      press(vecs[k].press);
      chk($sformatf("vec%0d_pend_latched", k), 32'(bus.PENDING), 32'(vecs[k].press));
      tick(1);
      chk($sformatf("vec%0d_vld_early", k), 32'(bus.REQ_VALID), 0);
      tick(1);
      chk($sformatf("vec%0d_vld", k), 32'(bus.REQ_VALID), 32'(vecs[k].exp_vld));
      if (vecs[k].exp_vld)
        chk($sformatf("vec%0d_floor", k), 32'(bus.REQUESTED_FLOOR), 32'(vecs[k].exp_floor));
      chk($sformatf("vec%0d_pend", k), 32'(bus.PENDING), 32'(vecs[k].exp_pend));
    end

    // Arrival in the first SERVE cycle is ignored; dwell length after arrival.
    do_reset();
    press(4'b0100);
    wait_vld(cyc, 10);
    chk("seq1_floor", 32'(bus.REQUESTED_FLOOR), 2);
    bus.CURRENT_FLOOR = 4'd2;
    bus.COMPLETE      = 1'b1;
    tick(1);
    chk("seq1_first_serve_ignored", 32'(bus.REQ_VALID), 1);
    tick(1);
    bus.COMPLETE = 1'b0;
    chk("seq1_arrive_vld", 32'(bus.REQ_VALID), 0);
    chk("seq1_arrive_pend", 32'(bus.PENDING), 0);
    n = 0;
    while (bus.BUSY && n < 100) begin
      n++;
      tick(1);
    end
    chk("seq1_dwell_cycles", 32'(n), DW);

    // Reversal: from floor 1 going up, calls at 0 and 3.
    do_reset();
    bus.CURRENT_FLOOR = 4'd1;
    tick(1);
    press(4'b1001);
    wait_vld(cyc, 10);
    chk("seq2_first", 32'(bus.REQUESTED_FLOOR), 3);
    tick(1);
    arrive(3);
    wait_vld(cyc, 50);
    chk("seq2_second", 32'(bus.REQUESTED_FLOOR), 0);
    tick(1);
    arrive(0);
    wait_idle(cyc, 50);
    chk("seq2_pend_empty", 32'(bus.PENDING), 0);

    // Weight alert freezes dwell and blocks the next dispatch.
    do_reset();
    press(4'b0010);
    wait_vld(cyc, 10);
    chk("seq3_first", 32'(bus.REQUESTED_FLOOR), 1);
    press(4'b1000);
    bus.WEIGHT_ALERT = 1'b1;
    arrive(1);
    tick(30);
    chk("seq3_busy_held", 32'(bus.BUSY), 1);
    chk("seq3_no_dispatch", 32'(bus.REQ_VALID), 0);
    chk("seq3_pend", 32'(bus.PENDING), 32'b1000);
    chk("seq3_floor_kept", 32'(bus.REQUESTED_FLOOR), 1);
    bus.WEIGHT_ALERT = 1'b0;
    wait_vld(cyc, 50);
    chk("seq3_resume_latency", 32'(cyc), DW + 2);
    chk("seq3_next", 32'(bus.REQUESTED_FLOOR), 3);

    // No retargeting while serving.
    do_reset();
    press(4'b0100);
    wait_vld(cyc, 10);
    press(4'b1000);
    tick(5);
    chk("seq4_hold_floor", 32'(bus.REQUESTED_FLOOR), 2);
    chk("seq4_hold_vld", 32'(bus.REQ_VALID), 1);
    chk("seq4_pend", 32'(bus.PENDING), 32'b1100);
    arrive(2);
    wait_vld(cyc, 50);
    chk("seq4_next", 32'(bus.REQUESTED_FLOOR), 3);

    // Watchdog (or its absence), then asynchronous reset during SERVE.
    do_reset();
    press(4'b1000);
    wait_vld(cyc, 10);
    chk("seq5_target", 32'(bus.REQUESTED_FLOOR), 3);
`ifdef DISPATCH_TIMEOUT_EN
    tick(TO - 1);
    chk("seq5_fault_before", 32'(bus.TIMEOUT_FAULT), 0);
    chk("seq5_vld_before", 32'(bus.REQ_VALID), 1);
    tick(1);
    chk("seq5_fault", 32'(bus.TIMEOUT_FAULT), 1);
    chk("seq5_vld_dropped", 32'(bus.REQ_VALID), 0);
    chk("seq5_pend_kept", 32'(bus.PENDING), 32'b1000);
    wait_vld(cyc, 50);
    chk("seq5_fault_sticky", 32'(bus.TIMEOUT_FAULT), 1);
`else
    tick(TO + 10);
    chk("seq5_no_fault", 32'(bus.TIMEOUT_FAULT), 0);
    chk("seq5_still_waiting", 32'(bus.REQ_VALID), 1);
`endif
    rst = 1'b0;
    #1;
    chk("seq5_rst_vld", 32'(bus.REQ_VALID), 0);
    chk("seq5_rst_floor", 32'(bus.REQUESTED_FLOOR), 0);
    chk("seq5_rst_pend", 32'(bus.PENDING), 0);
    chk("seq5_rst_busy", 32'(bus.BUSY), 0);
    chk("seq5_rst_fault", 32'(bus.TIMEOUT_FAULT), 0);
    tick(1);

    // Randomized call sets served to completion against the SCAN model.
    do_reset();
    for (int r = 0; r < 40; r++) begin
      cur  = $urandom_range(0, NF - 1);
      mset = NF'($urandom_range(1, (1 << NF) - 1));
      bus.CURRENT_FLOOR = FW'(cur);
      tick(1);
      press(mset);
      mset[cur] = 1'b0;
      if (mset == '0) begin
        tick(4);
        chk("rnd_local_no_vld", 32'(bus.REQ_VALID), 0);
        chk("rnd_local_pend", 32'(bus.PENDING), 0);
      end
      while (mset != '0) begin
        tgt = model_next(mset, cur);
        wait_vld(cyc, 20);
        chk("rnd_target", 32'(bus.REQUESTED_FLOOR), 32'(tgt));
        chk("rnd_pend_serve", 32'(bus.PENDING), 32'(mset));
        tick($urandom_range(1, 4));
        arrive(tgt);
        mset[tgt] = 1'b0;
        cur = tgt;
        chk("rnd_vld_drop", 32'(bus.REQ_VALID), 0);
        chk("rnd_pend_after", 32'(bus.PENDING), 32'(mset));
        wait_idle(cyc, 50);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/floor_request_dispatcher.md
Name: floor_request_dispatcher

Overview:
Request-side initiator for the elevator controller. It latches hall/car call buttons into a pending-floor set and picks the next target with SCAN (collective) ordering. It drives one target at a time on REQUESTED_FLOOR, holds it until the controller reports arrival via COMPLETE and OUT_CURRENT_FLOOR, then runs a door-dwell interval. It sits between the button panel and the controller, whose OUT_CURRENT_FLOOR, COMPLETE, DOOR_ALERT and WEIGHT_ALERT feed back into it.

Parameters:
NUM_FLOORS, 4, number of served floors (2..16); floor i maps to code i, ground = 0.
FLOOR_W, 4, floor code width.
DWELL_CYCLES, 8, idle cycles after each arrival before the next dispatch (>=1).
TIMEOUT_CYCLES, 64, arrival watchdog limit; used only with DISPATCH_TIMEOUT_EN.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset: asserting it (0) clears all state immediately; release is synchronous to clk.
CALL_BUTTONS  in  NUM_FLOORS  one bit per floor; level input, internally rising-edge detected.
CURRENT_FLOOR  in  FLOOR_W  controller's OUT_CURRENT_FLOOR.
COMPLETE  in  1  controller arrival flag.
DOOR_ALERT  in  1  controller door alert.
WEIGHT_ALERT  in  1  controller overweight alert.
REQUESTED_FLOOR  out  FLOOR_W  registered target floor for the controller.
REQ_VALID  out  1  high while REQUESTED_FLOOR is an active target.
PENDING  out  NUM_FLOORS  latched, not-yet-served calls.
BUSY  out  1  high in any state except IDLE.
TIMEOUT_FAULT  out  1  sticky watchdog fault; tied 0 without DISPATCH_TIMEOUT_EN.

Behaviour:
- Reset values (rst=0): REQUESTED_FLOOR=0, REQ_VALID=0, PENDING=0, BUSY=0, TIMEOUT_FAULT=0, sweep_up=1, state=IDLE, dwell counter=0, button-history register=0. Reset mid-service discards all pending calls and the active target.
- Button latch: a 0->1 edge on CALL_BUTTONS[i] sets PENDING[i] on that edge. A held button sets the bit only once.
- FSM states: IDLE, SELECT, SERVE, DWELL.
- IDLE: if PENDING[CURRENT_FLOOR]=1, clear that bit without dispatching (the car is already at that floor). Otherwise, if PENDING!=0 and no alert is active, go to SELECT.
- SELECT (one cycle): search in the sweep_up direction for the nearest pending floor strictly above (or below) CURRENT_FLOOR. If none exists, invert sweep_up and take the nearest pending floor in the opposite direction. Register it to REQUESTED_FLOOR, set REQ_VALID=1, go to SERVE. Result: REQ_VALID rises 2 edges after PENDING is set.
- SERVE: REQUESTED_FLOOR and REQ_VALID are held stable, with no retargeting even if new calls arrive. Arrival is COMPLETE=1 && CURRENT_FLOOR==REQUESTED_FLOOR, sampled no earlier than the second SERVE cycle.
- On arrival: clear PENDING[target], drop REQ_VALID, load the dwell counter, go to DWELL. If a press for the same floor arrives in the arrival cycle, clear wins.
- DWELL: count DWELL_CYCLES cycles, then go to IDLE. While DOOR_ALERT or WEIGHT_ALERT=1, the counter freezes and the FSM stays in DWELL. REQUESTED_FLOOR keeps its last value.
- Alerts in SERVE do not drop the target; the block simply keeps waiting.
- Arithmetic: comparisons are unsigned FLOOR_W. Button bits at or above NUM_FLOORS do not exist. A CURRENT_FLOOR value >= NUM_FLOORS blocks SELECT.

Optional Feature:
Macro DISPATCH_TIMEOUT_EN.
- With it: a counter runs in SERVE. If arrival has not occurred after TIMEOUT_CYCLES cycles, set TIMEOUT_FAULT (sticky until reset), drop REQ_VALID, keep PENDING[target] set, and go to DWELL.
- Without it: no counter exists, TIMEOUT_FAULT is constant 0, and SERVE waits indefinitely.

Decomposition:
- Shared package elevator_pkg holds:
  - FLOOR_W
  - floor constants GROUND=0, FIRST=1, SECOND=2, THIRD=3
  - direction encodings UP=1, DOWN=0
  - the dispatcher state enum
- Natural sub-module: scan_floor_selector. It is purely combinational and takes PENDING, CURRENT_FLOOR and sweep_up. It returns next_floor, found and new_sweep_up.

Test Plan:
- Reset with rst=0, then release; pulse CALL_BUTTONS=0100 with CURRENT_FLOOR=0 -> PENDING=0100 the next cycle, REQ_VALID=1 and REQUESTED_FLOOR=2 two edges later. Drive CURRENT_FLOOR=2 and COMPLETE=1 -> PENDING=0000, REQ_VALID=0, BUSY for DWELL_CYCLES, then IDLE.
- With CURRENT_FLOOR=1, sweep_up=1, press floors 0 and 3 together -> target 3 first, then 0 after arrival (reversal).
- Press floor 1 while CURRENT_FLOOR=1 in IDLE -> PENDING[1] cleared, REQ_VALID never asserted.
- Hold WEIGHT_ALERT=1 (WEIGHT_STATUS=5000 at the controller) during DWELL with floor 3 pending -> no dispatch until the alert drops, then REQUESTED_FLOOR=3.
- In SERVE targeting floor 2, press floor 3 -> REQUESTED_FLOOR stays 2 until arrival, then becomes 3.
- With DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=64: target 3, COMPLETE never asserted -> TIMEOUT_FAULT=1 at SERVE cycle 64, REQ_VALID=0, PENDING[3]=1. Assert rst mid-SERVE -> all outputs 0 immediately.
